// File: rtl/mc_req_to_bedrock_io.sv
// ============================================================================
//  Module   : mc_req_to_bedrock_io
//  Purpose  : Bridges a single manycore endpoint request into one uncached
//             BedRock memory command and returns the BedRock response (or an
//             error value) to the endpoint. One request is in flight at a time.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mc_bedrock_io_pkg;

  // Processor configurations known to this bridge.
  typedef enum logic [3:0] {
    e_bp_default_cfg = 4'd0
  } bp_params_e;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1 = 3'd0,
    e_bedrock_msg_size_2 = 3'd1,
    e_bedrock_msg_size_4 = 3'd2,
    e_bedrock_msg_size_8 = 3'd3
  } bp_bedrock_msg_size_e;

  localparam int unsigned bp_paddr_width_gp = 40;

  // Device windows in the physical address map.
  localparam logic [bp_paddr_width_gp-1:0] cfg_dev_base_addr_gp       = 40'h00_0020_0000;
  localparam logic [bp_paddr_width_gp-1:0] clint_dev_base_addr_gp     = 40'h00_0030_0000;
  localparam logic [bp_paddr_width_gp-1:0] cfg_mem_base_cce_ucode_gp  = 40'h00_0000_8000;

  typedef struct packed {
    logic [1:0] lce_id;
  } bp_bedrock_mem_payload_s;

  typedef struct packed {
    bp_bedrock_mem_payload_s         payload;
    bp_bedrock_msg_size_e            size;
    logic [bp_paddr_width_gp-1:0]    addr;
    logic [3:0]                      subop;
    bp_bedrock_mem_type_e            msg_type;
  } bp_bedrock_mem_header_s;

  typedef struct packed {
    logic [63:0]            data;
    bp_bedrock_mem_header_s header;
  } bp_bedrock_mem_msg_s;

  typedef struct packed {
    logic       is_byte_op;
    logic       is_hex_op;
    logic [1:0] part_sel;
  } bsg_manycore_load_info_s;

  // Configuration-derived widths; every configuration shares one message layout.
  function automatic int bp_paddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return int'(bp_paddr_width_gp);
      default:          return int'(bp_paddr_width_gp);
    endcase
  endfunction

  function automatic int bp_cce_mem_msg_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return $bits(bp_bedrock_mem_msg_s);
      default:          return $bits(bp_bedrock_mem_msg_s);
    endcase
  endfunction

endpackage

module mc_req_to_bedrock_io
  import mc_bedrock_io_pkg::*;
#(
  parameter bp_params_e bp_params_p      = e_bp_default_cfg,
  parameter int         mc_data_width_p  = 32,
  parameter int         mc_addr_width_p  = 28,
  parameter int         timeout_cycles_p = 1024,
  localparam int        paddr_width_p        = bp_paddr_width(bp_params_p),
  localparam int        cce_mem_msg_width_lp = bp_cce_mem_msg_width(bp_params_p)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,

  input  logic                            in_v_i,
  input  logic                            in_we_i,
  input  logic [mc_addr_width_p-1:0]      in_addr_i,
  input  logic [mc_data_width_p-1:0]      in_data_i,
  input  logic [3:0]                      in_mask_i,
  input  bsg_manycore_load_info_s         in_load_info_i,
  output logic                            in_yumi_o,

  output logic [cce_mem_msg_width_lp-1:0] io_cmd_o,
  output logic                            io_cmd_v_o,
  input  logic                            io_cmd_yumi_i,

  input  logic [cce_mem_msg_width_lp-1:0] io_resp_i,
  input  logic                            io_resp_v_i,
  output logic                            io_resp_ready_o,

  output logic [mc_data_width_p-1:0]      returning_data_o,
  output logic                            returning_v_o,
  output logic                            err_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEND   = 2'd1,
    S_WAIT   = 2'd2,
    S_RETURN = 2'd3
  } state_e;

  localparam int                CNT_W       = $clog2(timeout_cycles_p);
  localparam logic [CNT_W-1:0]  c_cnt_limit = CNT_W'(timeout_cycles_p - 1);

  state_e                       r_state;
  logic [CNT_W-1:0]             r_cnt;
  logic                         r_err;
  bp_bedrock_mem_msg_s          r_cmd;
  logic                         r_cmd_v;
  logic                         r_ret_v;
  logic [mc_data_width_p-1:0]   r_ret_data;
  logic [1:0]                   r_offset;

  logic [3:0]                   w_dev;
  logic [11:0]                  w_off;
  logic [paddr_width_p-1:0]     w_base;
  logic [paddr_width_p-1:0]     w_addr;
  logic                         w_dec_err;
  logic                         w_mask_err;
  bp_bedrock_msg_size_e         w_size;
  logic [1:0]                   w_offset;
  logic [mc_data_width_p-1:0]   w_data_shift;
  bp_bedrock_mem_msg_s          w_cmd;
  bp_bedrock_mem_msg_s          w_resp;
  logic                         w_unused_ok;

  assign w_dev  = in_addr_i[15:12];
  assign w_off  = in_addr_i[11:0];
  assign w_resp = bp_bedrock_mem_msg_s'(io_resp_i);

  // Device window decode from the upper nibble of the EPA.
  always_comb begin
    w_dec_err = 1'b0;
    w_base    = '0;
    case (w_dev)
      4'd0:    w_base = cfg_dev_base_addr_gp;
      4'd1:    w_base = cfg_dev_base_addr_gp + cfg_mem_base_cce_ucode_gp;
      4'd2:    w_base = clint_dev_base_addr_gp;
      default: w_dec_err = 1'b1;
    endcase
  end

  // Access size and byte lane: stores from the byte mask, loads from load info.
  always_comb begin
    w_size     = e_bedrock_msg_size_4;
    w_offset   = 2'd0;
    w_mask_err = 1'b0;
    if (in_we_i) begin
      case (in_mask_i)
        4'b0001: begin w_size = e_bedrock_msg_size_1; w_offset = 2'd0; end
        4'b0010: begin w_size = e_bedrock_msg_size_1; w_offset = 2'd1; end
        4'b0100: begin w_size = e_bedrock_msg_size_1; w_offset = 2'd2; end
        4'b1000: begin w_size = e_bedrock_msg_size_1; w_offset = 2'd3; end
        4'b0011: begin w_size = e_bedrock_msg_size_2; w_offset = 2'd0; end
        4'b1100: begin w_size = e_bedrock_msg_size_2; w_offset = 2'd2; end
        4'b1111: begin w_size = e_bedrock_msg_size_4; w_offset = 2'd0; end
        default: w_mask_err = 1'b1;
      endcase
    end else if (in_load_info_i.is_byte_op) begin
      w_size   = e_bedrock_msg_size_1;
      w_offset = in_load_info_i.part_sel;
    end else if (in_load_info_i.is_hex_op) begin
      w_size   = e_bedrock_msg_size_2;
      w_offset = {in_load_info_i.part_sel[1], 1'b0};
    end
  end

  assign w_addr       = w_base + paddr_width_p'(w_off) + paddr_width_p'(w_offset);
  assign w_data_shift = in_data_i >> {w_offset, 3'b000};

  // Assemble the outgoing command; unused header fields stay zero.
  always_comb begin
    w_cmd                       = '0;
    w_cmd.header.msg_type       = in_we_i ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
    w_cmd.header.addr           = w_addr;
    w_cmd.header.size           = w_size;
    w_cmd.header.payload.lce_id = 2'b10;
    w_cmd.data                  = in_we_i ? {2{w_data_shift}} : 64'd0;
  end

  // Request handshake, bridge sequencing, watchdog and sticky error.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_cmd      <= '0;
      r_cmd_v    <= 1'b0;
      r_ret_v    <= 1'b0;
      r_ret_data <= '0;
      r_offset   <= 2'd0;
    end else begin
      r_ret_v <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_v_i) begin
            r_offset <= w_offset;
            r_cmd    <= w_cmd;
            if (w_dec_err || w_mask_err) begin
              r_err      <= 1'b1;
              r_ret_data <= '0;
              r_ret_v    <= 1'b1;
              r_state    <= S_RETURN;
            end else begin
              r_cmd_v <= 1'b1;
              r_state <= S_SEND;
            end
          end
        end
        S_SEND: begin
          if (io_cmd_yumi_i) begin
            r_cmd_v <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response on the final watchdog cycle still counts as good data.
          if (io_resp_v_i) begin
            r_ret_data <= w_resp.data[31:0] << {r_offset, 3'b000};
            r_ret_v    <= 1'b1;
            r_state    <= S_RETURN;
          end else if (r_cnt == c_cnt_limit) begin
            r_ret_data <= 32'hDEAD_BEEF;
            r_err      <= 1'b1;
            r_ret_v    <= 1'b1;
            r_state    <= S_RETURN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RETURN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_yumi_o        = in_v_i && !reset_i && (r_state == S_IDLE);
  assign io_cmd_o         = r_cmd;
  assign io_cmd_v_o       = r_cmd_v;
  assign io_resp_ready_o  = 1'b1;
  assign returning_data_o = r_ret_data;
  assign returning_v_o    = r_ret_v;
  assign err_o            = r_err;

  // Response header, upper data and EPA bits above the decode field are ignored.
  assign w_unused_ok = ^{w_resp.header, w_resp.data[63:32], in_addr_i, bp_params_p};

endmodule

`default_nettype wire

// File: tb/tb_mc_req_to_bedrock_io.sv
// ============================================================================
//  Module   : tb_mc_req_to_bedrock_io
//  Purpose  : Self-checking bench for mc_req_to_bedrock_io using expected
//             command and return queues filled as requests are issued.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mc_req_to_bedrock_io;
  import mc_bedrock_io_pkg::*;

  localparam int TIMEOUT = 4;
  localparam int MSG_W   = $bits(bp_bedrock_mem_msg_s);

  typedef struct {
    logic [39:0]          addr;
    bp_bedrock_msg_size_e size;
    bp_bedrock_mem_type_e typ;
    logic [63:0]          data;
  } exp_cmd_t;

  logic                    clk = 1'b0;
  logic                    reset_i;
  logic                    in_v_i, in_we_i;
  logic [27:0]             in_addr_i;
  logic [31:0]             in_data_i;
  logic [3:0]              in_mask_i;
  bsg_manycore_load_info_s in_load_info_i;
  logic                    in_yumi_o;
  logic [MSG_W-1:0]        io_cmd_o;
  logic                    io_cmd_v_o, io_cmd_yumi_i;
  logic [MSG_W-1:0]        io_resp_i;
  logic                    io_resp_v_i, io_resp_ready_o;
  logic [31:0]             returning_data_o;
  logic                    returning_v_o, err_o;

  always #5 clk = ~clk;

  mc_req_to_bedrock_io #(
    .timeout_cycles_p (TIMEOUT)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .in_v_i           (in_v_i),
    .in_we_i          (in_we_i),
    .in_addr_i        (in_addr_i),
    .in_data_i        (in_data_i),
    .in_mask_i        (in_mask_i),
    .in_load_info_i   (in_load_info_i),
    .in_yumi_o        (in_yumi_o),
    .io_cmd_o         (io_cmd_o),
    .io_cmd_v_o       (io_cmd_v_o),
    .io_cmd_yumi_i    (io_cmd_yumi_i),
    .io_resp_i        (io_resp_i),
    .io_resp_v_i      (io_resp_v_i),
    .io_resp_ready_o  (io_resp_ready_o),
    .returning_data_o (returning_data_o),
    .returning_v_o    (returning_v_o),
    .err_o            (err_o)
  );

  int       n_checks = 0;
  int       n_errors = 0;
  int       n_ret    = 0;
  int       cyc      = 0;
  int       t_hs     = 0;
  int       t_ret    = 0;
  logic     prev_rv  = 1'b0;
  exp_cmd_t exp_cmd_q[$];
  logic [31:0] exp_ret_q[$];

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Command monitor: any valid command must have an expectation queued.
  always @(negedge clk) begin : mon_cmd
    exp_cmd_t               e;
    bp_bedrock_mem_msg_s    m;
    bp_bedrock_mem_header_s eh;
    if (!reset_i && io_cmd_v_o) begin
      if (exp_cmd_q.size() == 0) begin
        check_eq("unexpected_cmd", 1, 0);
      end else if (io_cmd_yumi_i) begin
        e  = exp_cmd_q.pop_front();
        m  = bp_bedrock_mem_msg_s'(io_cmd_o);
        eh = '0;
        eh.msg_type       = e.typ;
        eh.addr           = e.addr;
        eh.size           = e.size;
        eh.payload.lce_id = 2'b10;
        check_eq("cmd_addr", m.header.addr, e.addr);
        check_eq("cmd_size", m.header.size, e.size);
        check_eq("cmd_type", m.header.msg_type, e.typ);
        check_eq("cmd_data", m.data, e.data);
        check_eq("cmd_header", m.header, eh);
        t_hs = cyc;
      end
    end
  end

  // Return monitor: one-cycle pulse, data popped from the expected queue.
  always @(negedge clk) begin
    if (reset_i) begin
      prev_rv = 1'b0;
    end else begin
      if (returning_v_o) begin
        if (prev_rv) check_eq("ret_pulse_width", 1, 0);
        else if (exp_ret_q.size() == 0) check_eq("unexpected_ret", 1, 0);
        else begin
          check_eq("ret_data", returning_data_o, exp_ret_q.pop_front());
          n_ret++;
          t_ret = cyc;
        end
      end
      prev_rv = returning_v_o;
    end
  end

  task automatic push_cmd(input logic [39:0] a, input bp_bedrock_msg_size_e s,
                          input bp_bedrock_mem_type_e t, input logic [63:0] d);
    exp_cmd_t e;
    e.addr = a; e.size = s; e.typ = t; e.data = d;
    exp_cmd_q.push_back(e);
  endtask

  task automatic issue(input logic we, input logic [27:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, input logic byte_op, input logic hex_op,
                       input logic [1:0] part_sel, input logic hold);
    @(posedge clk); #1;
    in_v_i = 1'b1; in_we_i = we; in_addr_i = addr; in_data_i = data; in_mask_i = mask;
    in_load_info_i.is_byte_op = byte_op;
    in_load_info_i.is_hex_op  = hex_op;
    in_load_info_i.part_sel   = part_sel;
    @(negedge clk);
    check_eq("in_yumi_idle", in_yumi_o, 1);
    @(posedge clk); #1;
    if (!hold) in_v_i = 1'b0;
  endtask

  task automatic serve(input int yumi_delay, input logic resp_en, input int resp_delay,
                       input logic [63:0] resp_data);
    int               n;
    logic [MSG_W-1:0] snap;
    n = 0;
    @(negedge clk);
    while (!io_cmd_v_o && n < 20) begin @(negedge clk); n++; end
    if (!io_cmd_v_o) begin
      check_eq("cmd_valid_timeout", 0, 1);
      return;
    end
    snap = io_cmd_o;
    for (int i = 0; i < yumi_delay; i++) begin
      @(negedge clk);
      check_eq("cmd_stable", io_cmd_o, snap);
      check_eq("in_yumi_busy", in_yumi_o, 0);
    end
    @(posedge clk); #1;
    io_cmd_yumi_i = 1'b1;
    in_v_i        = 1'b0;
    @(posedge clk); #1;
    io_cmd_yumi_i = 1'b0;
    if (resp_en) begin
      repeat (resp_delay) begin @(posedge clk); #1; end
      io_resp_v_i = 1'b1;
      io_resp_i   = MSG_W'(resp_data) << $bits(bp_bedrock_mem_header_s);
      @(posedge clk); #1;
      io_resp_v_i = 1'b0;
    end
  endtask

  task automatic wait_ret(input int target);
    int n;
    n = 0;
    while (n_ret < target && n < 40) begin @(negedge clk); #1; n++; end
    check_eq("ret_count", n_ret, target);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; in_v_i = 1'b1; in_we_i = 1'b0; in_addr_i = '0; in_data_i = '0;
    in_mask_i = '0; in_load_info_i = '0; io_cmd_yumi_i = 1'b0; io_resp_i = '0; io_resp_v_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_yumi", in_yumi_o, 0);
    check_eq("rst_cmd_v", io_cmd_v_o, 0);
    check_eq("rst_ret_v", returning_v_o, 0);
    check_eq("rst_ret_data", returning_data_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_resp_ready", io_resp_ready_o, 1);
    @(posedge clk); #1;
    reset_i = 1'b0; in_v_i = 1'b0;

    // Word load from the CLINT window.
    push_cmd(clint_dev_base_addr_gp + 40'h8, e_bedrock_msg_size_4, e_bedrock_mem_uc_rd, 64'h0);
    exp_ret_q.push_back(32'h1234_5678);
    issue(1'b0, 28'h000_2008, 32'h0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    serve(0, 1'b1, 1, 64'h0000_0000_1234_5678);
    wait_ret(1);

    // Byte store into lane 2 of the config window.
    push_cmd(cfg_dev_base_addr_gp + 40'h2, e_bedrock_msg_size_1, e_bedrock_mem_uc_wr, 64'h0000_00AB_0000_00AB);
    exp_ret_q.push_back(32'h0055_0000);
    issue(1'b1, 28'h000_0000, 32'h00AB_0000, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b0);
    serve(0, 1'b1, 0, 64'hFFFF_FFFF_0000_0055);
    wait_ret(2);

    // Half-word load from the ucode window, upper half.
    push_cmd(cfg_dev_base_addr_gp + cfg_mem_base_cce_ucode_gp + 40'h6, e_bedrock_msg_size_2,
             e_bedrock_mem_uc_rd, 64'h0);
    exp_ret_q.push_back(32'hBEEF_0000);
    issue(1'b0, 28'h000_1004, 32'h0, 4'h0, 1'b0, 1'b1, 2'd2, 1'b0);
    serve(0, 1'b1, 2, 64'h0000_0000_0000_BEEF);
    wait_ret(3);

    // Byte load, lane 3.
    push_cmd(cfg_dev_base_addr_gp + 40'h13, e_bedrock_msg_size_1, e_bedrock_mem_uc_rd, 64'h0);
    exp_ret_q.push_back(32'hA500_0000);
    issue(1'b0, 28'h000_0010, 32'h0, 4'h0, 1'b1, 1'b0, 2'd3, 1'b0);
    serve(0, 1'b1, 0, 64'h0000_0000_0000_00A5);
    wait_ret(4);

    // Full-word store to the CLINT window.
    push_cmd(clint_dev_base_addr_gp + 40'hF0, e_bedrock_msg_size_4, e_bedrock_mem_uc_wr, 64'hDEAD_C0DE_DEAD_C0DE);
    exp_ret_q.push_back(32'h0);
    issue(1'b1, 28'h000_20F0, 32'hDEAD_C0DE, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
    serve(0, 1'b1, 1, 64'h0);
    wait_ret(5);

    // Upper half-word store; response lands on the last watchdog cycle.
    push_cmd(cfg_dev_base_addr_gp + 40'h2, e_bedrock_msg_size_2, e_bedrock_mem_uc_wr, 64'h0000_CAFE_0000_CAFE);
    exp_ret_q.push_back(32'h0001_0000);
    issue(1'b1, 28'h000_0000, 32'hCAFE_1234, 4'b1100, 1'b0, 1'b0, 2'd0, 1'b0);
    serve(0, 1'b1, TIMEOUT - 1, 64'h1);
    wait_ret(6);
    check_eq("err_after_late_ok", err_o, 0);

    // Illegal store masks return zero without a command.
    exp_ret_q.push_back(32'h0);
    issue(1'b1, 28'h000_0000, 32'hFFFF_FFFF, 4'b0101, 1'b0, 1'b0, 2'd0, 1'b0);
    wait_ret(7);
    check_eq("err_bad_mask", err_o, 1);
    exp_ret_q.push_back(32'h0);
    issue(1'b1, 28'h000_0000, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    wait_ret(8);

    do_reset();
    check_eq("err_cleared", err_o, 0);

    // Undecodable device.
    exp_ret_q.push_back(32'h0);
    issue(1'b0, 28'h000_5000, 32'h0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    wait_ret(9);
    check_eq("err_bad_dev", err_o, 1);

    do_reset();

    // Watchdog expiry, then a stale response, then a normal request.
    push_cmd(clint_dev_base_addr_gp, e_bedrock_msg_size_4, e_bedrock_mem_uc_rd, 64'h0);
    exp_ret_q.push_back(32'hDEAD_BEEF);
    issue(1'b0, 28'h000_2000, 32'h0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    serve(0, 1'b0, 0, 64'h0);
    wait_ret(10);
    check_eq("timeout_latency", t_ret - t_hs, TIMEOUT + 1);
    check_eq("err_timeout", err_o, 1);
    @(posedge clk); #1;
    io_resp_v_i = 1'b1; io_resp_i = '1;
    @(posedge clk); #1;
    io_resp_v_i = 1'b0;
    repeat (3) @(posedge clk);
    push_cmd(cfg_dev_base_addr_gp + 40'h20, e_bedrock_msg_size_4, e_bedrock_mem_uc_rd, 64'h0);
    exp_ret_q.push_back(32'h0BAD_F00D);
    issue(1'b0, 28'h000_0020, 32'h0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    serve(0, 1'b1, 0, 64'h0000_0000_0BAD_F00D);
    wait_ret(11);

    do_reset();

    // Stalled command with the endpoint still requesting, then reset in WAIT.
    push_cmd(cfg_dev_base_addr_gp, e_bedrock_msg_size_1, e_bedrock_mem_uc_wr, 64'h0000_0011_0000_0011);
    issue(1'b1, 28'h000_0000, 32'h0000_0011, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b1);
    serve(10, 1'b0, 0, 64'h0);
    repeat (2) @(posedge clk);
    do_reset();
    @(posedge clk); #1;
    io_resp_v_i = 1'b1; io_resp_i = '1;
    @(posedge clk); #1;
    io_resp_v_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("no_ret_after_reset", returning_v_o, 0);
    end

    push_cmd(clint_dev_base_addr_gp + 40'h4, e_bedrock_msg_size_4, e_bedrock_mem_uc_rd, 64'h0);
    exp_ret_q.push_back(32'h1357_2468);
    issue(1'b0, 28'h000_2004, 32'h0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    serve(0, 1'b1, 0, 64'h0000_0000_1357_2468);
    wait_ret(12);

    repeat (2) @(posedge clk);
    check_eq("cmd_q_drained", exp_cmd_q.size(), 0);
    check_eq("ret_q_drained", exp_ret_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
